// File: rtl/score_display.sv
// Score to 4-digit 7-seg: double-dabble BCD (18 clk to digits), leading-zero blanking, multiplexed refresh.
// No backpressure: score changes during a conversion are ignored and the latest value is reconverted.
module score_display #(
    parameter int CLK_FREQ   = 100000000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] score,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);
    localparam int DIV = CLK_FREQ / REFRESH_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t      state, state_nx;
    logic [15:0] last_val;
    logic [15:0] sh;
    logic [19:0] bcd;
    logic [19:0] bcd_adj;
    logic [3:0]  bit_cnt;
    logic [3:0]  d3, d2, d1, d0;
    logic [CW-1:0] ref_cnt;
    logic [1:0]  sel;
    logic [3:0]  cur;
    logic        blank;

    function automatic logic [6:0] seg_dec(input logic [3:0] v);
        case (v)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b1111111;
        endcase
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (score != last_val) state_nx = CONV;
            CONV:    if (bit_cnt == 4'd15)  state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_val <= '0;
            sh       <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            d3 <= '0; d2 <= '0; d1 <= '0; d0 <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (score != last_val) begin
                    last_val <= score;
                    sh       <= score;
                    bcd      <= '0;
                    bit_cnt  <= '0;
                end
                CONV: begin
                    bcd     <= 20'({bcd_adj, sh[15]});
                    sh      <= {sh[14:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                UPDATE: begin
                    // Values beyond four digits saturate the display.
                    if (last_val > 16'd9999) begin
                        d3 <= 4'd9; d2 <= 4'd9; d1 <= 4'd9; d0 <= 4'd9;
                    end else begin
                        d3 <= bcd[15:12]; d2 <= bcd[11:8]; d1 <= bcd[7:4]; d0 <= bcd[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt <= '0;
            sel     <= '0;
        end else if (ref_cnt == CW'(DIV - 1)) begin
            ref_cnt <= '0;
            sel     <= sel + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    always_comb begin
        cur   = d0;
        blank = 1'b0;
        case (sel)
            2'd0: cur = d0;
            2'd1: cur = d1;
            2'd2: begin cur = d2; blank = (d3 == 4'd0) && (d2 == 4'd0); end
            2'd3: begin cur = d3; blank = (d3 == 4'd0); end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << sel);
            seg <= blank ? 7'b1111111 : seg_dec(cur);
            dp  <= (sel != 2'd1);
        end
    end
endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a fast refresh (4-clock digit period).
module tb_score_display;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] score;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;
    logic busy_seen = 1'b0;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S9 = 7'b0010000,
                           S7 = 7'b1111000;

    score_display #(.CLK_FREQ(8), .REFRESH_HZ(2)) dut (
        .clk(clk), .reset(reset), .score(score),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_en && busy === 1'b1) busy_seen = 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_an(input int k);
        logic [3:0] ea;
        int n;
        ea = ~(4'b0001 << k);
        n = 0;
        while (an !== ea && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("an_reach%0d", k), {12'd0, an}, {12'd0, ea});
    endtask

    task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                 input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] e [4];
        e[3] = e3; e[2] = e2; e[1] = e1; e[0] = e0;
        for (int k = 3; k >= 0; k--) begin
            wait_an(k);
            chk($sformatf("%s_seg%0d", tag, k), {9'd0, seg}, {9'd0, e[k]});
            chk($sformatf("%s_dp%0d", tag, k), {15'd0, dp}, (k == 1) ? 16'd0 : 16'd1);
        end
    endtask

    task automatic wait_conv(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 30) begin step(); n++; end
        chk({tag, "_busy_rise"}, {15'd0, busy}, 16'd1);
        n = 0;
        while (busy !== 1'b0 && n < 30) begin step(); n++; end
        chk({tag, "_busy_fall"}, {15'd0, busy}, 16'd0);
        step();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        score = 16'd0;
        repeat (3) step();
        chk("rst_an",   {12'd0, an},   16'b1110);
        chk("rst_seg",  {9'd0, seg},   {9'd0, S0});
        chk("rst_dp",   {15'd0, dp},   16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);

        // Zero held through release: period and blanking.
        reset = 1'b0;
        mon_en = 1'b1;
        check_display("zero", BLK, BLK, S0, S0);
        wait_an(1);
        repeat (3) step();
        chk("period_hold", {12'd0, an}, 16'b1101);
        step();
        chk("period_adv", {12'd0, an}, 16'b1011);
        mon_en = 1'b0;
        chk("zero_no_busy", {15'd0, busy_seen}, 16'd0);

        // 1234: busy for 17 cycles, digits written 18 clocks after the step.
        score = 16'd1234;
        step();
        chk("b1234_first", {15'd0, busy}, 16'd1);
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            step();
            if (busy === 1'b1) n++;
        end
        chk("b1234_len", 16'(n), 16'd17);
        chk("d1234", {dut.d3, dut.d2, dut.d1, dut.d0}, 16'h1234);
        check_display("v1234", S1, S2, S3, S4);

        score = 16'd65535;
        wait_conv("v65535");
        check_display("v65535", S9, S9, S9, S9);

        score = 16'd7;
        wait_conv("v7");
        check_display("v7", BLK, BLK, S0, S7);

        // Change to 200 on the 5th CONV cycle is held off until the next IDLE.
        score = 16'd100;
        step();
        chk("b100_rise", {15'd0, busy}, 16'd1);
        repeat (4) step();
        score = 16'd200;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin step(); n++; end
        chk("b100_len", 16'(n), 16'd13);
        chk("d100", {dut.d3, dut.d2, dut.d1, dut.d0}, 16'h0100);
        step();
        chk("b200_rise", {15'd0, busy}, 16'd1);
        wait_conv("v200");
        chk("d200", {dut.d3, dut.d2, dut.d1, dut.d0}, 16'h0200);
        check_display("v200", BLK, S2, S0, S0);

        // Reset on the 8th CONV cycle aborts; reconversion follows release.
        score = 16'd4321;
        step();
        chk("b4321_rise", {15'd0, busy}, 16'd1);
        repeat (7) step();
        reset = 1'b1;
        step();
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_an",   {12'd0, an},   16'b1110);
        chk("abort_seg",  {9'd0, seg},   {9'd0, S0});
        chk("abort_digits", {dut.d3, dut.d2, dut.d1, dut.d0}, 16'h0000);
        reset = 1'b0;
        wait_conv("v4321");
        chk("d4321", {dut.d3, dut.d2, dut.d1, dut.d0}, 16'h4321);
        check_display("v4321", S4, S3, S2, S1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
